// File: rtl/mcu_pkg.sv
// mcu_pkg: shared constants and PC-select encoding for the MCU program-counter unit
package mcu_pkg;
  localparam int ADDR_WIDTH_DEF = 8;
  typedef enum logic [2:0] {PC_HOLD, PC_RET, PC_CALL, PC_BRANCH, PC_SEQ} pc_sel_t;
endpackage

// File: rtl/mcu_lifo_stack.sv
// mcu_lifo_stack: return-address LIFO that ignores push-when-full and pop-when-empty
module mcu_lifo_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign top   = empty ? '0 : mem[AW'(count - 1'b1)];
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (push && !full) count <= count + 1'b1;
    else if (pop && !empty) count <= count - 1'b1;
  // Entries are never reset; only count defines what is valid.
  always_ff @(posedge clk)
    if (!rst && push && !full) mem[AW'(count)] <= din;
endmodule

// File: rtl/mcu_pc_stack_unit.sv
// mcu_pc_stack_unit: registered PC with stall, branch and call/return via a hardware stack
module mcu_pc_stack_unit
  import mcu_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int STACK_DEPTH = 4,
  parameter int PC_STEP     = 1,
  localparam int CW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] resetPC,
  input  logic                  stall,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  call_en,
  input  logic                  ret_en,
  output logic [ADDR_WIDTH-1:0] currentPC,
  output logic [CW-1:0]         stack_count,
  output logic                  stack_overflow,
  output logic                  stack_underflow
);
  pc_sel_t               sel;
  logic [ADDR_WIDTH-1:0] pc_inc, top, pc_next;
  logic                  full, empty;
  assign pc_inc = currentPC + ADDR_WIDTH'(PC_STEP);
  assign sel = stall     ? PC_HOLD   :
               ret_en    ? PC_RET    :
               call_en   ? PC_CALL   :
               branch_en ? PC_BRANCH : PC_SEQ;
  always_comb
    pc_next = sel == PC_HOLD   ? currentPC :
              sel == PC_RET    ? (empty ? resetPC : top) :
              sel == PC_CALL   ? (full ? pc_inc : branch_target) :
              sel == PC_BRANCH ? branch_target : pc_inc;
  mcu_lifo_stack #(.DEPTH(STACK_DEPTH), .WIDTH(ADDR_WIDTH)) u_stack (
    .clk(Clk),
    .rst(Reset),
    .push(sel == PC_CALL),
    .pop(sel == PC_RET),
    .din(pc_inc),
    .top(top),
    .count(stack_count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge Clk)
    if (Reset) begin
      currentPC       <= resetPC;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      currentPC       <= pc_next;
      stack_overflow  <= stack_overflow | (sel == PC_CALL && full);
      stack_underflow <= stack_underflow | (sel == PC_RET && empty);
    end
endmodule

// File: tb/tb_mcu_pc_stack_unit.sv
// tb_mcu_pc_stack_unit: queue-based reference model compared every cycle, plus directed literal checks
module tb_mcu_pc_stack_unit;
  localparam int DEPTH = 4;
  logic       Clk = 0, Reset, stall, branch_en, call_en, ret_en;
  logic [7:0] resetPC, branch_target, currentPC;
  logic [2:0] stack_count;
  logic       stack_overflow, stack_underflow;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_pc;
  logic [7:0] q[$];
  logic       m_ov, m_un;
  bit         valid = 0;

  mcu_pc_stack_unit #(.ADDR_WIDTH(8), .STACK_DEPTH(DEPTH), .PC_STEP(1)) dut (
    .Clk(Clk), .Reset(Reset), .resetPC(resetPC), .stall(stall),
    .branch_en(branch_en), .branch_target(branch_target), .call_en(call_en),
    .ret_en(ret_en), .currentPC(currentPC), .stack_count(stack_count),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // At each negedge: compare against the model, then advance it with the inputs the next edge will sample.
  always @(negedge Clk) begin
    if (valid) begin
      chk("model_pc", currentPC, m_pc);
      chk("model_count", stack_count, q.size());
      chk("model_ovf", stack_overflow, m_ov);
      chk("model_unf", stack_underflow, m_un);
    end
    if (Reset) begin
      m_pc = resetPC; q.delete(); m_ov = 0; m_un = 0; valid = 1;
    end else if (valid && !stall) begin
      if (ret_en) begin
        if (q.size() > 0) m_pc = q.pop_back();
        else begin m_pc = resetPC; m_un = 1; end
      end else if (call_en) begin
        if (q.size() < DEPTH) begin q.push_back(8'(m_pc + 8'd1)); m_pc = branch_target; end
        else begin m_pc = 8'(m_pc + 8'd1); m_ov = 1; end
      end else if (branch_en) m_pc = branch_target;
      else m_pc = 8'(m_pc + 8'd1);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic go(input logic [7:0] t);
    branch_en = 1; branch_target = t; cyc(); branch_en = 0;
  endtask

  task automatic call(input logic [7:0] t);
    call_en = 1; branch_target = t; cyc(); call_en = 0;
  endtask

  task automatic ret();
    ret_en = 1; cyc(); ret_en = 0;
  endtask

  initial begin
    Reset = 1; resetPC = 8'h10; stall = 0; branch_en = 0; call_en = 0; ret_en = 0;
    branch_target = 0;
    cyc(2);
    chk("reset_pc", currentPC, 8'h10);
    chk("reset_count", stack_count, 0);
    chk("reset_flags", {stack_overflow, stack_underflow}, 0);
    Reset = 0;
    cyc(); chk("seq_11", currentPC, 8'h11);
    cyc(); chk("seq_12", currentPC, 8'h12);
    go(8'hFE); chk("branch_fe", currentPC, 8'hFE);
    cyc(); chk("wrap_ff", currentPC, 8'hFF);
    cyc(); chk("wrap_00", currentPC, 8'h00);
    cyc(); chk("wrap_01", currentPC, 8'h01);
    go(8'h20);
    call(8'h40); chk("call_pc", currentPC, 8'h40); chk("call_count", stack_count, 1);
    cyc(2); chk("after_call_seq", currentPC, 8'h42);
    ret(); chk("ret_pc", currentPC, 8'h21); chk("ret_count", stack_count, 0);
    go(8'h4F);
    call(8'h50); call(8'h51); call(8'h52); call(8'h53);
    chk("full_count", stack_count, 4); chk("full_pc", currentPC, 8'h53);
    call(8'h99);
    chk("ovf_pc", currentPC, 8'h54); chk("ovf_count", stack_count, 4);
    chk("ovf_flag", stack_overflow, 1);
    ret(); chk("pop1", currentPC, 8'h53);
    ret(); chk("pop2", currentPC, 8'h52);
    ret(); chk("pop3", currentPC, 8'h51);
    ret(); chk("pop4", currentPC, 8'h50);
    chk("pop_count", stack_count, 0);
    ret(); chk("unf_pc", currentPC, 8'h10); chk("unf_flag", stack_underflow, 1);
    chk("unf_count", stack_count, 0);
    go(8'h80); call(8'h90); cyc(3); ret();
    chk("unf_sticky", stack_underflow, 1); chk("ovf_sticky", stack_overflow, 1);
    Reset = 1; cyc(); Reset = 0;
    chk("flags_cleared", {stack_overflow, stack_underflow}, 0);
    go(8'h30); call(8'h70);
    stall = 1; call_en = 1; branch_en = 1; branch_target = 8'hAA; cyc(2);
    stall = 0; call_en = 0; branch_en = 0;
    chk("stall_pc", currentPC, 8'h70); chk("stall_count", stack_count, 1);
    ret_en = 1; call_en = 1; branch_target = 8'hBB; cyc(); ret_en = 0; call_en = 0;
    chk("ret_wins_pc", currentPC, 8'h31); chk("ret_wins_count", stack_count, 0);
    call(8'h60); call(8'h61);
    resetPC = 8'h08; Reset = 1; call_en = 1; branch_target = 8'hCC; cyc();
    Reset = 0; call_en = 0;
    chk("rst_call_pc", currentPC, 8'h08); chk("rst_call_count", stack_count, 0);
    cyc(); chk("rst_call_seq", currentPC, 8'h09);
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
